// File: rtl/vga_timing_ctrl.sv
// VGA horizontal/vertical timing generator advanced by a pixel-enable tick.
// Optional 8-bit frame counter when VGA_FRAME_COUNT_EN is defined.
module vga_timing_ctrl #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned SYNC_POL  = 0
) (
  input  logic       mclk,
  input  logic       clr,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] px,
  output logic [9:0] py,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast     = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast     = 10'(V_TOTAL - 1);
  localparam logic [9:0] HVis      = 10'(H_VISIBLE);
  localparam logic [9:0] VVis      = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncBeg  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HSyncEnd  = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncBeg  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VSyncEnd  = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic       SyncOn    = (SYNC_POL != 0);

  logic [9:0] px_q, px_d, py_q, py_d;
  logic       h_wrap, v_wrap, line_wrap, frame_wrap;
  logic       hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;

  always_comb begin
    h_wrap     = (px_q == HLast);
    v_wrap     = (py_q == VLast);
    line_wrap  = pix_en & h_wrap;
    frame_wrap = line_wrap & v_wrap;
    px_d       = px_q;
    py_d       = py_q;
    if (pix_en) begin
      px_d = h_wrap ? 10'd0 : px_q + 10'd1;
      if (h_wrap) begin
        py_d = v_wrap ? 10'd0 : py_q + 10'd1;
      end
    end
  end

  // Level outputs decode the next-state counters so they line up with px/py.
  always_ff @(posedge mclk) begin
    if (clr) begin
      px_q          <= HLast;
      py_q          <= VLast;
      hsync_q       <= ~SyncOn;
      vsync_q       <= ~SyncOn;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      px_q          <= px_d;
      py_q          <= py_d;
      hsync_q       <= (px_d >= HSyncBeg && px_d < HSyncEnd) ? SyncOn : ~SyncOn;
      vsync_q       <= (py_d >= VSyncBeg && py_d < VSyncEnd) ? SyncOn : ~SyncOn;
      video_on_q    <= (px_d < HVis) && (py_d < VVis);
      line_start_q  <= line_wrap;
      frame_start_q <= frame_wrap;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge mclk) begin
    if (clr) begin
      frame_cnt_q <= 8'd0;
    end else if (frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign px          = px_q;
  assign py          = py_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-size instance and a tiny active-high-sync instance
// driven by the same stimulus and checked against a tick-count reference model.
module tb_vga_timing_ctrl;

  typedef struct {
    int hv, hfp, hs, hbp, vv, vfp, vs, vbp;
    logic pol;
  } tim_t;

  typedef struct {
    int   px, py, fc;
    logic hs, vs, vid;
  } exp_t;

  typedef struct {
    logic clr, pix_en;
    int   px, py;
    logic vid, hs, vs, ls, fs;
  } vec_t;

  localparam tim_t FullT  = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
  localparam tim_t SmallT = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1};

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic pix_en = 1'b0;

  logic       f_hs, f_vs, f_vid, f_ls, f_fs;
  logic [9:0] f_px, f_py;
  logic       s_hs, s_vs, s_vid, s_ls, s_fs;
  logic [9:0] s_px, s_py;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] f_fc, s_fc;
`endif

  int errors = 0;
  int checks = 0;
  int n = 0;           // pixel ticks since the last reset
  bit last_tick = 0;   // previous edge advanced the counters

  always #5 clk = ~clk;

  vga_timing_ctrl u_full (
    .mclk        (clk),
    .clr         (clr),
    .pix_en      (pix_en),
    .hsync       (f_hs),
    .vsync       (f_vs),
    .video_on    (f_vid),
    .px          (f_px),
    .py          (f_py),
    .line_start  (f_ls),
    .frame_start (f_fs)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_cnt   (f_fc)
`endif
  );

  vga_timing_ctrl #(
    .H_VISIBLE (4),
    .H_FP      (1),
    .H_SYNC    (2),
    .H_BP      (1),
    .V_VISIBLE (3),
    .V_FP      (1),
    .V_SYNC    (1),
    .V_BP      (1),
    .SYNC_POL  (1)
  ) u_small (
    .mclk        (clk),
    .clr         (clr),
    .pix_en      (pix_en),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .video_on    (s_vid),
    .px          (s_px),
    .py          (s_py),
    .line_start  (s_ls),
    .frame_start (s_fs)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_cnt   (s_fc)
`endif
  );

  // Position is the (n-1)th pixel of an endless raster; n=0 maps to the last pixel.
  function automatic exp_t model(input tim_t t, input int ticks);
    exp_t e;
    int ht, vt, f, k;
    logic hact, vact;
    ht = t.hv + t.hfp + t.hs + t.hbp;
    vt = t.vv + t.vfp + t.vs + t.vbp;
    f  = ht * vt;
    k  = (((ticks - 1) % f) + f) % f;
    e.px  = k % ht;
    e.py  = k / ht;
    e.vid = (e.px < t.hv) && (e.py < t.vv);
    hact  = (e.px >= t.hv + t.hfp) && (e.px < t.hv + t.hfp + t.hs);
    vact  = (e.py >= t.vv + t.vfp) && (e.py < t.vv + t.vfp + t.vs);
    e.hs  = hact ? t.pol : ~t.pol;
    e.vs  = vact ? t.pol : ~t.pol;
    e.fc  = (ticks == 0) ? 0 : (((ticks - 1) / f) + 1) % 256;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tick %0d, t=%0t)", name, act, req, n, $time);
    end
  endtask

  task automatic check_dut(input string tag, input tim_t t, input logic [9:0] px,
                           input logic [9:0] py, input logic hs, input logic vs,
                           input logic vid, input logic ls, input logic fs);
    exp_t e;
    e = model(t, n);
    chk({tag, ".px"}, 32'(px), 32'(e.px));
    chk({tag, ".py"}, 32'(py), 32'(e.py));
    chk({tag, ".hsync"}, 32'(hs), 32'(e.hs));
    chk({tag, ".vsync"}, 32'(vs), 32'(e.vs));
    chk({tag, ".video_on"}, 32'(vid), 32'(e.vid));
    chk({tag, ".line_start"}, 32'(ls), 32'(last_tick && e.px == 0));
    chk({tag, ".frame_start"}, 32'(fs), 32'(last_tick && e.px == 0 && e.py == 0));
  endtask

  task automatic step(input logic c, input logic p);
    @(negedge clk);
    clr    = c;
    pix_en = p;
    @(posedge clk);
    #1;
    if (c) begin
      n = 0;
      last_tick = 0;
    end else begin
      if (p) n++;
      last_tick = p;
    end
    check_dut("full", FullT, f_px, f_py, f_hs, f_vs, f_vid, f_ls, f_fs);
    check_dut("small", SmallT, s_px, s_py, s_hs, s_vs, s_vid, s_ls, s_fs);
`ifdef VGA_FRAME_COUNT_EN
    chk("full.frame_cnt", 32'(f_fc), 32'(model(FullT, n).fc));
    chk("small.frame_cnt", 32'(s_fc), 32'(model(SmallT, n).fc));
`endif
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b1);
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].clr, vecs[i].pix_en);
      chk("vec.px", 32'(f_px), 32'(vecs[i].px));
      chk("vec.py", 32'(f_py), 32'(vecs[i].py));
      chk("vec.video_on", 32'(f_vid), 32'(vecs[i].vid));
      chk("vec.hsync", 32'(f_hs), 32'(vecs[i].hs));
      chk("vec.vsync", 32'(f_vs), 32'(vecs[i].vs));
      chk("vec.line_start", 32'(f_ls), 32'(vecs[i].ls));
      chk("vec.frame_start", 32'(f_fs), 32'(vecs[i].fs));
    end

    // Line boundaries on the full-size raster with pix_en held high.
    step(1'b1, 1'b0);
    ticks(640);
    chk("seq.px639", 32'(f_px), 32'd639);
    chk("seq.vid639", 32'(f_vid), 32'd1);
    ticks(1);
    chk("seq.vid640", 32'(f_vid), 32'd0);
    ticks(16);
    chk("seq.px656", 32'(f_px), 32'd656);
    chk("seq.hs656", 32'(f_hs), 32'd0);
    ticks(95);
    chk("seq.hs751", 32'(f_hs), 32'd0);
    ticks(1);
    chk("seq.hs752", 32'(f_hs), 32'd1);
    ticks(48);
    chk("seq.wrap_px", 32'(f_px), 32'd0);
    chk("seq.wrap_py", 32'(f_py), 32'd1);
    chk("seq.wrap_ls", 32'(f_ls), 32'd1);
    chk("seq.wrap_fs", 32'(f_fs), 32'd0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0);
    chk("seq.frozen_px", 32'(f_px), 32'd0);
    chk("seq.frozen_py", 32'(f_py), 32'd1);
    chk("seq.frozen_ls", 32'(f_ls), 32'd0);

    // Mid-frame clear with pix_en high: no strobe on the reset edge.
    ticks(300);
    step(1'b1, 1'b1);
    chk("seq.clr_px", 32'(f_px), 32'd799);
    chk("seq.clr_py", 32'(f_py), 32'd524);
    chk("seq.clr_fs", 32'(f_fs), 32'd0);
    chk("seq.clr_ls", 32'(f_ls), 32'd0);
    chk("seq.clr_vid", 32'(f_vid), 32'd0);
    step(1'b0, 1'b1);
    chk("seq.restart_fs", 32'(f_fs), 32'd1);

    // Random pix_en density with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      logic c, p;
      c = ($urandom_range(0, 399) == 0);
      p = (i < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(c, p);
    end

`ifdef VGA_FRAME_COUNT_EN
    step(1'b1, 1'b0);
    ticks(97);
    chk("fc.three", 32'(s_fc), 32'd3);
    ticks(12241 - 97);
    chk("fc.wrap", 32'(s_fc), 32'd0);
    ticks(48);
    chk("fc.after_wrap", 32'(s_fc), 32'd1);
    step(1'b1, 1'b0);
    chk("fc.clr", 32'(s_fc), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
